belief_normalizer: RTL
======================

// Module: belief_normalizer
// PURPOSE
//  Collects N_CENT non-negative belief values for one DeSTIN node and sums them.
//  Drives the external cordic_div for each value: divident = value, division = sum>>FRAC.
//  Streams the Q(FRAC) normalised beliefs downstream, with out_ready backpressure.
//  Sits directly upstream of cordic_div, which it feeds, and consumes the divider's quotients.
// PARAMETERS
//  N_CENT  4   belief values per node (>=2)
//  FRAC    8   fractional bits of the normalised output
//  SW      18  sum accumulator width (>= 16 + clog2(N_CENT))
// PORTS
//  clk           in   1   system clock, rising edge
//  rst           in   1   asynchronous reset, active-low
//  in_valid      in   1   input belief valid
//  in_data       in   16  signed belief value
//  in_ready      out  1   high in LOAD: block accepts in_data
//  div_en        out  1   one-cycle start pulse to cordic_div
//  div_divident  out  16  signed dividend, held stable until div_flag
//  div_division  out  16  unsigned divisor, held stable until div_flag
//  div_flag      in   1   cordic_div completion pulse
//  div_quotient  in   16  signed cordic_div result, valid with div_flag
//  out_valid     out  1   normalised belief valid; held until out_ready
//  out_data      out  16  signed Q(FRAC) normalised belief
//  out_idx       out  8   index 0..N_CENT-1 of out_data
//  out_last      out  1   high with out_valid on the last index
//  zero_sum      out  1   sticky per frame: the sum was 0
// BEHAVIOUR
//  Reset (rst low, async): state=LOAD, all outputs 0 except in_ready=1.
//    Buffer, sum and index cleared. A reset mid-frame abandons the frame.
//  LOAD:
//    Each cycle with in_valid & in_ready, store max(in_data,0) in buf[idx] and add it to sum.
//    Negative inputs are clamped to 0 before both the store and the add.
//    After N_CENT accepts: in_ready=0, go to SCALE.
//  SCALE (1 cycle):
//    div_division = sum>>FRAC, saturated to 16'hFFFF.
//    If the result is 0, force it to 1.
//    zero_sum = (sum==0). Reset idx to 0, go to ISSUE.
//  ISSUE (1 cycle):
//    div_divident = buf[idx], div_en=1, go to WAIT.
//    div_en is only issued while cordic_div is idle; at most one request is outstanding.
//  WAIT:
//    div_en=0. On div_flag: out_data = div_quotient, out_valid=1, out_idx = idx,
//    out_last = (idx==N_CENT-1); go to OUT.
//    A div_flag seen in any other state is ignored.
//  OUT:
//    Hold out_* stable until out_ready. On out_valid & out_ready:
//    out_valid=0; if last, go to LOAD (in_ready=1 next cycle), else idx++ and go to ISSUE.
//  Latency per value: 1 (ISSUE) + cordic_div time (17 cycles) + 1 (output register).
//    Zero extra cycles when out_ready is held high.
//  in_data is never accepted outside LOAD, so no new frame overlaps the output phase.
//  The quotient passes through unchanged, including the divider's +/-1 LSB residue.
// CONFIGURATION
//  BELIEF_NORM_UNIFORM_EN defined:
//    When zero_sum, SCALE goes straight to a BYPASS path; the divider is never started.
//    Each out_data = (1<<FRAC)/N_CENT (constant). Handshake, out_idx and out_last unchanged.
//  Undefined:
//    When zero_sum, division is forced to 1; the divider runs normally and outputs are 0 (+/-1 LSB).
// STRUCTURE
//  Package belief_norm_pkg:
//    state encoding localparams (LOAD, SCALE, ISSUE, WAIT, OUT, BYPASS)
//    DW=16, default FRAC, divisor saturation constant.
//  No sub-module: one FSM, a buf register array and the sum accumulator.
//  cordic_div is instantiated beside this block by the parent, not inside it.
// TESTING (N_CENT=4, FRAC=8, bench instantiates the real cordic_div; quotient checks are +/-1 LSB)
//  Frame 64,64,64,64 -> division=1; out_data ~64 x4, out_idx 0..3, out_last only on idx 3.
//  Frame 512,256,256,0 -> division=4; out_data ~128,64,64,0.
//  Frame -5,100,100,56 -> buf[0]=0, sum=256; out_data ~0,100,100,56.
//  Frame 0,0,0,0 -> zero_sum=1.
//    With BELIEF_NORM_UNIFORM_EN: out_data=64 x4 and div_en never pulses.
//    Without it: out_data ~0 x4.
//  out_ready held low 10 cycles at idx 1 -> out_data/out_idx stable, no div_en until the accept.
//  rst pulsed low during WAIT at idx 2 -> all outputs 0 at once.
//    in_ready=1 after release; the next full frame normalises correctly.

Source files
------------

// File: rtl/belief_norm_pkg.sv
// Shared constants for the belief normaliser: data width, default fraction
// bits, divisor saturation value and FSM state encodings.
package belief_norm_pkg;

  localparam int DW       = 16;
  localparam int FRAC_DEF = 8;

  // Largest divisor the 16-bit unsigned divider port can carry.
  localparam logic [DW-1:0] DIV_SAT = 16'hFFFF;

  // FSM state encodings.
  localparam logic [2:0] ST_LOAD   = 3'd0;
  localparam logic [2:0] ST_SCALE  = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_OUT    = 3'd4;
  localparam logic [2:0] ST_BYPASS = 3'd5;

  // Negative beliefs carry no probability mass: clamp them to zero.
  function automatic logic [DW-1:0] clamp_nonneg(input logic [DW-1:0] v);
    return v[DW-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/belief_normalizer.sv
// belief_normalizer: collects N_CENT belief values of one DeSTIN node, sums
// them, then drives an external cordic_div once per value (dividend = value,
// divisor = sum >> FRAC) and streams the quotients out with backpressure.
// Optional feature macro: BELIEF_NORM_UNIFORM_EN -- when the sum is zero the
// divider is skipped and every output is the uniform value (1<<FRAC)/N_CENT.
module belief_normalizer
  import belief_norm_pkg::*;
#(
  parameter int N_CENT = 4,
  parameter int FRAC   = FRAC_DEF,
  parameter int SW     = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        div_en,
  output logic [15:0] div_divident,
  output logic [15:0] div_division,
  input  logic        div_flag,
  input  logic [15:0] div_quotient,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [7:0]  out_idx,
  output logic        out_last,
  output logic        zero_sum
);

  localparam int IW = (N_CENT > 1) ? $clog2(N_CENT) : 1;

`ifdef BELIEF_NORM_UNIFORM_EN
  localparam logic [DW-1:0] UNIFORM_Q = DW'((1 << FRAC) / N_CENT);
`endif

  logic [2:0]    r_state;
  logic [7:0]    r_idx;
  logic [SW-1:0] r_sum;
  logic [DW-1:0] r_buf [N_CENT];

  logic          r_div_en;
  logic [DW-1:0] r_div_divident;
  logic [DW-1:0] r_div_division;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [7:0]    r_out_idx;
  logic          r_out_last;
  logic          r_zero_sum;

  logic          w_accept;
  logic [DW-1:0] w_in_clamped;
  logic          w_last_idx;
  logic          w_sum_zero;
  logic [SW-1:0] w_sum_shift;
  logic [DW-1:0] w_div_sat;
  logic [DW-1:0] w_buf_sel;
  logic [2:0]    w_next_issue;

  assign in_ready     = (r_state == ST_LOAD);
  assign w_accept     = in_valid & in_ready;
  assign w_in_clamped = clamp_nonneg(in_data);
  assign w_last_idx   = (r_idx == 8'(N_CENT - 1));
  assign w_sum_zero   = (r_sum == '0);
  assign w_sum_shift  = r_sum >> FRAC;
  assign w_buf_sel    = r_buf[r_idx[IW-1:0]];

`ifdef BELIEF_NORM_UNIFORM_EN
  assign w_next_issue = r_zero_sum ? ST_BYPASS : ST_ISSUE;
`else
  assign w_next_issue = ST_ISSUE;
`endif

  // Divisor: sum >> FRAC saturated to 16 bits, never zero.
  always_comb begin
    w_div_sat = w_sum_shift[DW-1:0];
    if (w_sum_shift > SW'(DIV_SAT))
      w_div_sat = DIV_SAT;
    if (w_div_sat == '0)
      w_div_sat = 16'd1;
  end

  // One buffer entry per centroid, written when its index is accepted.
  generate
    for (genvar gi = 0; gi < N_CENT; gi++) begin : g_buf
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          r_buf[gi] <= '0;
        else if (w_accept && (r_idx == 8'(gi)))
          r_buf[gi] <= w_in_clamped;
      end
    end
  endgenerate

  // Main FSM: load/sum, scale, issue division, wait for quotient, hand off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_LOAD;
      r_idx          <= '0;
      r_sum          <= '0;
      r_div_en       <= 1'b0;
      r_div_divident <= '0;
      r_div_division <= '0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_idx      <= '0;
      r_out_last     <= 1'b0;
      r_zero_sum     <= 1'b0;
    end else begin
      r_div_en <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            r_sum <= r_sum + SW'(w_in_clamped);
            if (w_last_idx) begin
              r_idx   <= '0;
              r_state <= ST_SCALE;
            end else begin
              r_idx <= r_idx + 8'd1;
            end
          end
        end
        ST_SCALE: begin
          r_div_division <= w_div_sat;
          r_zero_sum     <= w_sum_zero;
          r_idx          <= '0;
`ifdef BELIEF_NORM_UNIFORM_EN
          r_state        <= w_sum_zero ? ST_BYPASS : ST_ISSUE;
`else
          r_state        <= ST_ISSUE;
`endif
        end
        ST_ISSUE: begin
          r_div_divident <= w_buf_sel;
          r_div_en       <= 1'b1;
          r_state        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (div_flag) begin
            r_out_data  <= div_quotient;
            r_out_valid <= 1'b1;
            r_out_idx   <= r_idx;
            r_out_last  <= w_last_idx;
            r_state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_out_last) begin
              r_sum   <= '0;
              r_idx   <= '0;
              r_state <= ST_LOAD;
            end else begin
              r_idx   <= r_idx + 8'd1;
              r_state <= w_next_issue;
            end
          end
        end
`ifdef BELIEF_NORM_UNIFORM_EN
        ST_BYPASS: begin
          r_out_data  <= UNIFORM_Q;
          r_out_valid <= 1'b1;
          r_out_idx   <= r_idx;
          r_out_last  <= w_last_idx;
          r_state     <= ST_OUT;
        end
`endif
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign div_en       = r_div_en;
  assign div_divident = r_div_divident;
  assign div_division = r_div_division;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_idx      = r_out_idx;
  assign out_last     = r_out_last;
  assign zero_sum     = r_zero_sum;

endmodule
